// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;
  localparam int HOLD_W      = 3;

  localparam logic [INST_ADDR_W-1:0] INST_ADDR_NOP = 32'h0000_0000;
  localparam logic [INST_W-1:0]      INST_NOP      = 32'h0000_0001;
  localparam logic [HOLD_W-1:0]      HOLD_PC       = 3'b001;
  localparam logic                   RST_ENABLE    = 1'b0;

  typedef enum logic {
    IFU_STATE_BOOT = 1'b0,
    IFU_STATE_RUN  = 1'b1
  } ifu_state_e;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } ifu_entry_t;

  function automatic logic [INST_ADDR_W-1:0] word_align(input logic [INST_ADDR_W-1:0] addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction bus between the fetch unit (master) and instruction memory (slave).
interface ifu_fetch_if;
  import ifu_fetch_pkg::*;

  // Handshake: a read is accepted in the cycle where req && gnt; while req is high
  // and ungranted, addr is held. rvalid returns data in request order, at least one
  // cycle after the matching grant, with no back-pressure from the master.
  logic                   req;
  logic [INST_ADDR_W-1:0] addr;
  logic                   gnt;
  logic                   rvalid;
  logic [INST_W-1:0]      rdata;

  modport master (output req, addr, input gnt, rvalid, rdata);
  modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/ifu_fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, inst} pairs; flush wins over push/pop.
module ifu_fetch_fifo
  import ifu_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  ifu_entry_t    din,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output ifu_entry_t    head
);

  ifu_entry_t      mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit feeding IF/ID: sequential PC, bus reads, response buffer, redirects.
// Optional macro IFU_MISALIGN_CHECK_EN adds the misalign_err output for unaligned jump targets.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int                     FIFO_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   jump_flag,
  input  logic [INST_ADDR_W-1:0] jump_addr,
  input  logic [HOLD_W-1:0]      hold_flag,
  ifu_fetch_if.master            ibus,
  output logic [INST_ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0]      if_inst,
`ifdef IFU_MISALIGN_CHECK_EN
  output logic                   misalign_err,
`endif
  output ifu_state_e             dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e             state_q;
  ifu_state_e             state_d;
  logic [INST_ADDR_W-1:0] fetch_pc;
  logic [INST_ADDR_W-1:0] resp_pc;
  logic [INST_ADDR_W-1:0] jump_target;
  logic [CW-1:0]          outstanding;
  logic [CW-1:0]          outstanding_next;
  logic [CW-1:0]          discard;
  logic [CW-1:0]          fifo_count;
  logic [CW:0]            in_flight;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   stall;
  logic                   credit_ok;
  logic                   req;
  logic                   grant;
  logic                   resp;
  logic                   push;
  logic                   pop;
  ifu_entry_t             push_entry;
  ifu_entry_t             head;

  assign stall       = (hold_flag & HOLD_PC) == HOLD_PC;
  assign jump_target = word_align(jump_addr);

  // Buffered plus in-flight reads never exceed the FIFO, so a response always has a slot.
  assign in_flight = {1'b0, fifo_count} + {1'b0, outstanding};
  assign credit_ok = !fifo_full && (in_flight < (CW+1)'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) state_q <= IFU_STATE_BOOT;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    case (state_q)
      IFU_STATE_BOOT: state_d = IFU_STATE_RUN;
      IFU_STATE_RUN:  req     = !jump_flag && credit_ok;
      default:        state_d = IFU_STATE_BOOT;
    endcase
  end

  assign ibus.req  = req;
  assign ibus.addr = fetch_pc;
  assign dbg_state = state_q;

  assign grant            = req && ibus.gnt;
  assign resp             = ibus.rvalid && (outstanding != '0);
  assign outstanding_next = outstanding + CW'(grant) - CW'(resp);
  assign push             = resp && (discard == '0) && !jump_flag;
  assign pop              = !fifo_empty && !stall && !jump_flag;
  assign push_entry       = '{pc: resp_pc, inst: ibus.rdata};

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (jump_flag) begin
        // Every read still in flight after this cycle belongs to the abandoned stream.
        fetch_pc <= jump_target;
        resp_pc  <= jump_target;
        discard  <= outstanding_next;
      end else begin
        if (grant)                   fetch_pc <= fetch_pc + 32'd4;
        if (resp && discard != '0)   discard  <= discard - 1'b1;
        if (push)                    resp_pc  <= resp_pc + 32'd4;
      end
    end
  end

  ifu_fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (jump_flag),
    .din   (push_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count),
    .head  (head)
  );

  assign if_pc   = (!fifo_empty && !jump_flag) ? head.pc   : INST_ADDR_NOP;
  assign if_inst = (!fifo_empty && !jump_flag) ? head.inst : INST_NOP;

`ifdef IFU_MISALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) misalign_err <= 1'b0;
    else                   misalign_err <= jump_flag && (jump_addr[1:0] != 2'b00);
  end
`else
  logic unused_jump_low;
  assign unused_jump_low = ^jump_addr[1:0];
`endif

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: bus responder model, reference scoreboard, vectors.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam int          DEPTH  = 2;
  localparam logic [31:0] KEY    = 32'hA5A5_0000;
  localparam logic [31:0] PC_NOP = 32'h0000_0000;
  localparam logic [31:0] I_NOP  = 32'h0000_0001;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        jump_flag;
  logic [31:0] jump_addr;
  logic [2:0]  hold_flag;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  ifu_state_e  dbg_state;
`ifdef IFU_MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  ifu_fetch_if ibus ();

  ifu_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .jump_flag (jump_flag),
    .jump_addr (jump_addr),
    .hold_flag (hold_flag),
    .ibus      (ibus),
    .if_pc     (if_pc),
    .if_inst   (if_inst),
`ifdef IFU_MISALIGN_CHECK_EN
    .misalign_err (misalign_err),
`endif
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard / reference model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic        live;
    logic        keep;
  } pend_t;

  logic [63:0] exp_q[$];
  pend_t       resp_q[$];
  int          total = 0;
  int          bad   = 0;
  bit          m_run;
  logic [31:0] m_pc;
  bit          m_mis;
  bit          gnt_en;
  bit          resp_stall;
  logic        s_req;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_inst;

  task automatic check1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive bus, sample at mid-cycle, compare with model, advance model.
  task automatic step();
    logic        stall;
    logic        exp_req;
    logic        show;
    logic        deliver;
    int          live_n;
    logic [63:0] front;
    pend_t       cur;
    pend_t       p;
    cur = '0;
    if (!rst) begin
      exp_q.delete();
      m_pc  = 32'h0;
      m_run = 1'b0;
      m_mis = 1'b0;
      for (int i = 0; i < resp_q.size(); i++) begin
        p = resp_q[i]; p.live = 1'b0; p.keep = 1'b0; resp_q[i] = p;
      end
    end
    deliver     = !resp_stall && (resp_q.size() > 0);
    ibus.gnt    = gnt_en;
    ibus.rvalid = deliver;
    ibus.rdata  = deliver ? (resp_q[0].addr ^ KEY) : 32'($urandom);
    #1;
    stall  = (hold_flag & 3'b001) == 3'b001;
    live_n = 0;
    foreach (resp_q[i]) if (resp_q[i].live) live_n++;
    exp_req = rst && m_run && !jump_flag && ((exp_q.size() + live_n) < DEPTH);
    show    = rst && !jump_flag && (exp_q.size() > 0);
    front   = show ? exp_q[0] : {PC_NOP, I_NOP};
    s_req   = ibus.req;
    s_addr  = ibus.addr;
    s_pc    = if_pc;
    s_inst  = if_inst;
    check1 ("ibus_req",  s_req, exp_req);
    check32("ibus_addr", s_addr, m_pc);
    check32("if_pc",     s_pc, front[63:32]);
    check32("if_inst",   s_inst, front[31:0]);
    check1 ("state_run", dbg_state == IFU_STATE_RUN, m_run);
`ifdef IFU_MISALIGN_CHECK_EN
    check1 ("misalign_err", misalign_err, m_mis);
`endif
    if (deliver) cur = resp_q.pop_front();
    if (rst) begin
      if (show && !stall) void'(exp_q.pop_front());
      if (deliver && cur.live && cur.keep && !jump_flag)
        exp_q.push_back({cur.addr, cur.addr ^ KEY});
      if (exp_req && gnt_en) begin
        resp_q.push_back('{addr: m_pc, live: 1'b1, keep: 1'b1});
        m_pc = m_pc + 32'd4;
      end
      m_mis = jump_flag && (jump_addr[1:0] != 2'b00);
      if (jump_flag) begin
        exp_q.delete();
        m_pc = {jump_addr[31:2], 2'b00};
        for (int i = 0; i < resp_q.size(); i++) begin
          p = resp_q[i]; p.keep = 1'b0; resp_q[i] = p;
        end
      end
      m_run = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; jump_flag = 1'b0; jump_addr = '0; hold_flag = '0;
    gnt_en = 1'b1; resp_stall = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  // Steps until an instruction is visible (bounded), then checks it.
  task automatic next_visible(input string name, input logic [31:0] pc);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (s_inst == I_NOP && n < 20);
    check32({name, "_pc"},   s_pc, pc);
    check32({name, "_inst"}, s_inst, pc ^ KEY);
  endtask

  // Steps until the model's head entry is the given pc (bounded).
  task automatic wait_front(input logic [31:0] pc);
    logic [63:0] f;
    int n;
    n = 0;
    f = '0;
    while (n < 40) begin
      if (exp_q.size() > 0) f = exp_q[0];
      if (exp_q.size() > 0 && f[63:32] == pc) break;
      step();
      n++;
    end
    check1("wait_front_timeout", n < 40, 1'b1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0]  hold;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_show;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[8];

  initial begin
    rst = 1'b0; jump_flag = 1'b0; jump_addr = '0; hold_flag = '0;
    gnt_en = 1'b1; resp_stall = 1'b0;
    ibus.gnt = 1'b0; ibus.rvalid = 1'b0; ibus.rdata = '0;
    m_run = 1'b0; m_pc = '0; m_mis = 1'b0;
    @(negedge clk);

    // Cycle 0 is BOOT; gnt tied high, one-cycle response latency.
    vecs[0] = '{3'b000, 1'b0, 32'h0,  1'b0, 32'h0};
    vecs[1] = '{3'b010, 1'b1, 32'h0,  1'b0, 32'h0};
    vecs[2] = '{3'b000, 1'b1, 32'h4,  1'b0, 32'h0};
    vecs[3] = '{3'b010, 1'b0, 32'h8,  1'b1, 32'h0};
    vecs[4] = '{3'b000, 1'b1, 32'h8,  1'b1, 32'h4};
    vecs[5] = '{3'b010, 1'b1, 32'hC,  1'b0, 32'h0};
    vecs[6] = '{3'b000, 1'b0, 32'h10, 1'b1, 32'h8};
    vecs[7] = '{3'b000, 1'b1, 32'h10, 1'b1, 32'hC};

    do_reset();
    for (int i = 0; i < 8; i++) begin
      hold_flag = vecs[i].hold;
      step();
      check1 ("vec_req",  s_req, vecs[i].exp_req);
      check32("vec_addr", s_addr, vecs[i].exp_addr);
      check32("vec_pc",   s_pc, vecs[i].exp_show ? vecs[i].exp_pc : PC_NOP);
      check32("vec_inst", s_inst, vecs[i].exp_show ? (vecs[i].exp_pc ^ KEY) : I_NOP);
    end
    hold_flag = '0;

    // Grant withheld: request and address must hold steady.
    do_reset();
    gnt_en = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      step();
      check1 ("nognt_req",  s_req, 1'b1);
      check32("nognt_addr", s_addr, 32'h0);
    end
    gnt_en = 1'b1;
    step();
    check1 ("gnt_req",  s_req, 1'b1);
    check32("gnt_addr", s_addr, 32'h0);
    step();
    check32("gnt_next_addr", s_addr, 32'h4);

    // Stall with pc 0x8 at the head.
    wait_front(32'h8);
    for (int i = 0; i < 6; i++) begin
      hold_flag = (i < 3) ? 3'b001 : 3'b011;
      step();
      check32("stall_pc",   s_pc, 32'h8);
      check32("stall_inst", s_inst, 32'h8 ^ KEY);
    end
    hold_flag = '0;
    step();
    next_visible("stall_resume", 32'hC);

    // Jump with two reads outstanding; one response lands in the jump cycle.
    do_reset();
    resp_stall = 1'b1;
    step();
    step();
    step();
    step();
    check1("two_outstanding_no_req", s_req, 1'b0);
    resp_stall = 1'b0;
    jump_flag  = 1'b1;
    jump_addr  = 32'h100;
    step();
    check1 ("jump_req",  s_req, 1'b0);
    check32("jump_pc",   s_pc, PC_NOP);
    check32("jump_inst", s_inst, I_NOP);
    jump_flag = 1'b0;
    next_visible("after_jump", 32'h100);

    // PC wraps past the top of the address space.
    jump_flag = 1'b1;
    jump_addr = 32'hFFFF_FFFC;
    step();
    jump_flag = 1'b0;
    next_visible("wrap_top", 32'hFFFF_FFFC);
    next_visible("wrap_zero", 32'h0);

    // Reset mid-fetch; the pending response only arrives after release.
    do_reset();
    step();
    step();
    check1("pre_rst_req", s_req, 1'b1);
    rst = 1'b0;
    resp_stall = 1'b1;
    step();
    step();
    rst = 1'b1;
    resp_stall = 1'b0;
    step();
    check1 ("post_rst_boot_req",  s_req, 1'b0);
    check32("post_rst_boot_inst", s_inst, I_NOP);
    step();
    check1 ("post_rst_req",  s_req, 1'b1);
    check32("post_rst_addr", s_addr, 32'h0);
    next_visible("post_rst", 32'h0);

`ifdef IFU_MISALIGN_CHECK_EN
    jump_flag = 1'b1;
    jump_addr = 32'h102;
    step();
    jump_flag = 1'b0;
    step();
    check1 ("misalign_high", misalign_err, 1'b1);
    check32("misalign_addr", s_addr, 32'h100);
    step();
    check1 ("misalign_low", misalign_err, 1'b0);
`endif

    // Random traffic against the scoreboard.
    for (int i = 0; i < 300; i++) begin
      gnt_en     = ($urandom_range(0, 3) != 0);
      resp_stall = ($urandom_range(0, 3) == 0);
      hold_flag  = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
      jump_flag  = ($urandom_range(0, 15) == 0);
      jump_addr  = 32'($urandom);
      step();
    end
    jump_flag = 1'b0; hold_flag = '0; gnt_en = 1'b1; resp_stall = 1'b0;
    for (int i = 0; i < 10; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
